// File: rtl/pad_encoder16.sv
// 16-pad press encoder: synchronise, debounce and edge-detect each pad, queue
// presses in a pending set, and deliver 4-bit codes (pN -> N-1) over valid/ready.
module pad_encoder16 #(
  parameter int DEB_TICK = 50000,
  parameter int TW       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p1,
  input  logic        p2,
  input  logic        p3,
  input  logic        p4,
  input  logic        p5,
  input  logic        p6,
  input  logic        p7,
  input  logic        p8,
  input  logic        p9,
  input  logic        p10,
  input  logic        p11,
  input  logic        p12,
  input  logic        p13,
  input  logic        p14,
  input  logic        p15,
  input  logic        p16,
  output logic [3:0]  Dout,
  output logic        Dout_valid,
  input  logic        Dout_ready,
  output logic        ovf,
  output logic [15:0] pressed
);

  logic [15:0]   pad_raw;
  logic [15:0]   sync_a;
  logic [15:0]   s;
  logic [15:0]   samp;
  logic [15:0]   match;
  logic [15:0]   pressed_d;
  logic [15:0]   evt_q;
  logic [15:0]   pending;
  logic [15:0]   low_bit;
  logic [15:0]   take;
  logic [3:0]    low_idx;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          load;

  assign pad_raw = {p16, p15, p14, p13, p12, p11, p10, p9,
                    p8,  p7,  p6,  p5,  p4,  p3,  p2,  p1};

  assign tick  = (tick_cnt == TW'(DEB_TICK - 1));
  assign match = ~(s ^ samp);

  // Two's-complement trick isolates the lowest set bit, giving p1-first priority.
  assign low_bit = pending & (~pending + 16'd1);
  assign load    = !Dout_valid || Dout_ready;
  assign take    = load ? low_bit : 16'd0;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    low_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (pending[i]) low_idx = 4'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a     <= '0;
      s          <= '0;
      samp       <= '0;
      pressed    <= '0;
      pressed_d  <= '0;
      evt_q      <= '0;
      pending    <= '0;
      tick_cnt   <= '0;
      Dout       <= '0;
      Dout_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      sync_a    <= pad_raw;
      s         <= sync_a;
      tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);

      if (tick) begin
        samp    <= s;
        pressed <= (s & match) | (pressed & ~match);
      end

      pressed_d <= pressed;
      evt_q     <= pressed & ~pressed_d;

      // A press landing on the bit being handed out this cycle re-arms it
      // rather than counting as a lost press.
      pending <= (pending & ~take) | evt_q;
      if (|(evt_q & pending & ~take)) ovf <= 1'b1;

      if (load) begin
        if (|pending) begin
          Dout       <= low_idx;
          Dout_valid <= 1'b1;
        end else begin
          Dout_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pad_encoder16.sv
// Scoreboard bench for pad_encoder16: stimulus pushes expected codes, a
// negedge monitor pops and compares on every accepted handshake.
module tb_pad_encoder16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pads = 16'd0;
  logic        Dout_ready = 1'b1;
  logic [3:0]  Dout;
  logic        Dout_valid;
  logic        ovf;
  logic [15:0] pressed;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  pad_encoder16 #(.DEB_TICK(4), .TW(16)) dut (
    .clk(clk), .rst(rst),
    .p1(pads[0]),   .p2(pads[1]),   .p3(pads[2]),   .p4(pads[3]),
    .p5(pads[4]),   .p6(pads[5]),   .p7(pads[6]),   .p8(pads[7]),
    .p9(pads[8]),   .p10(pads[9]),  .p11(pads[10]), .p12(pads[11]),
    .p13(pads[12]), .p14(pads[13]), .p15(pads[14]), .p16(pads[15]),
    .Dout(Dout), .Dout_valid(Dout_valid), .Dout_ready(Dout_ready),
    .ovf(ovf), .pressed(pressed)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops on each accepted handshake and checks stall stability.
  logic       prev_stall = 1'b0;
  logic [3:0] prev_dout  = 4'd0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, Dout_valid}, 32'd1);
        check("stall_dout", {28'd0, Dout}, {28'd0, prev_dout});
      end
      if (Dout_valid && Dout_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event actual=%0h expected=none", Dout);
        end else begin
          check("event_code", {28'd0, Dout}, {28'd0, exp_q.pop_front()});
        end
      end
      prev_stall = Dout_valid && !Dout_ready;
      prev_dout  = Dout;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    rst = 1'b1;
    cycles(2);
    check("rst_valid", {31'd0, Dout_valid}, 32'd0);
    check("rst_dout", {28'd0, Dout}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_pressed", {16'd0, pressed}, 32'd0);
    rst = 1'b0;
    cycles(2);

    // Single press of p6, then release yields nothing
    Dout_ready = 1'b1;
    exp_q.push_back(4'd5);
    pads[5] = 1'b1;
    cycles(20);
    check("single_pressed", {16'd0, pressed}, 32'h0020);
    wait_drain("single_drain");
    check("single_valid_drop", {31'd0, Dout_valid}, 32'd0);
    pads[5] = 1'b0;
    cycles(25);
    check("single_release", {16'd0, pressed}, 32'd0);

    // Bouncing p3 settles to one press
    exp_q.push_back(4'd2);
    for (int i = 0; i < 10; i++) begin
      pads[2] = ~pads[2];
      cycles(1);
    end
    pads[2] = 1'b1;
    cycles(25);
    wait_drain("bounce_drain");
    pads[2] = 1'b0;
    cycles(25);

    // Priority and stall: p16 and p2 together while stalled
    Dout_ready = 1'b0;
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd15);
    pads[15] = 1'b1;
    pads[1]  = 1'b1;
    cycles(25);
    check("prio_valid", {31'd0, Dout_valid}, 32'd1);
    check("prio_first", {28'd0, Dout}, 32'd1);
    Dout_ready = 1'b1;
    @(negedge clk);
    check("prio_b2b_first", {27'd0, Dout_valid, Dout}, 32'h11);
    @(negedge clk);
    check("prio_b2b_second", {27'd0, Dout_valid, Dout}, 32'h1F);
    wait_drain("prio_drain");
    pads[15] = 1'b0;
    pads[1]  = 1'b0;
    cycles(25);

    // Overflow: p9 pressed twice while p1 code is stalled
    Dout_ready = 1'b0;
    exp_q.push_back(4'd0);
    pads[0] = 1'b1;
    cycles(25);
    check("ovf_before", {31'd0, ovf}, 32'd0);
    exp_q.push_back(4'd8);
    repeat (2) begin
      pads[8] = 1'b1;
      cycles(16);
      pads[8] = 1'b0;
      cycles(16);
    end
    check("ovf_set", {31'd0, ovf}, 32'd1);
    pads[0] = 1'b0;
    Dout_ready = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_sticky", {31'd0, ovf}, 32'd1);
    cycles(25);
    check("ovf_sticky_late", {31'd0, ovf}, 32'd1);

    // Mid-operation reset discards the stalled event
    Dout_ready = 1'b0;
    exp_q.push_back(4'd3);
    pads[3] = 1'b1;
    cycles(25);
    check("midrst_valid_before", {27'd0, Dout_valid, Dout}, 32'h13);
    rst = 1'b1;
    pads[3] = 1'b0;
    exp_q.delete();
    cycles(1);
    check("midrst_valid", {31'd0, Dout_valid}, 32'd0);
    check("midrst_ovf", {31'd0, ovf}, 32'd0);
    check("midrst_pressed", {16'd0, pressed}, 32'd0);
    rst = 1'b0;
    Dout_ready = 1'b1;
    cycles(30);
    check("midrst_no_event", {31'd0, Dout_valid}, 32'd0);
    check("final_queue", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
